// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and the bit vote.
`timescale 1ns/1ps
package uart_pkg;

   localparam int DATA_BITS       = 8;
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_MID        = UART_OVERSAMPLE / 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } uart_state_e;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous pad inputs.
`timescale 1ns/1ps
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {STAGES{RESET_VAL}};
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = UART_OVERSAMPLE,
   parameter int SYNC_STAGES = 2
) (
   input  logic       mclk,
   input  logic       reset_n,
   input  logic       baud_x16,
   input  logic       serial,
   output logic [7:0] data,
   output logic       data_strobe,
   output logic       framing_error,
   output logic       parity_error,
   output logic       busy
);

   localparam int MID = OVERSAMPLE / 2;
   localparam int CW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [CW-1:0] T_LO  = CW'(MID - 1);
   localparam logic [CW-1:0] T_MID = CW'(MID);
   localparam logic [CW-1:0] T_HI  = CW'(MID + 1);
   localparam logic [CW-1:0] T_END = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] T_ARM = CW'(SYNC_STAGES);
   localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

   uart_state_e         r_state;
   logic [CW-1:0]       r_tick;
   logic [BW-1:0]       r_bit;
   logic [1:0]          r_smp;
   logic [7:0]          r_shift;
   logic [7:0]          r_data;
   logic                r_strobe;
   logic                r_ferr;
   logic                r_armed;
   logic                w_line;
   logic                w_eval;
   logic                w_vote;
   logic [CW-1:0]       w_tick_inc;

   sync_ff #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .i_clk   (mclk),
      .i_rst_n (reset_n),
      .i_d     (serial),
      .o_q     (w_line)
   );

   assign w_eval     = (r_tick == T_HI);
   assign w_vote     = maj3({r_smp, w_line});
   assign w_tick_inc = (r_tick == T_END) ? '0 : r_tick + 1'b1;

`ifdef UART_RX_PARITY_EN
   logic r_perr;
   logic r_perr_pend;
`endif

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_tick   <= '0;
         r_bit    <= '0;
         r_smp    <= '0;
         r_shift  <= '0;
         r_data   <= '0;
         r_strobe <= 1'b0;
         r_ferr   <= 1'b0;
         r_armed  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr      <= 1'b0;
         r_perr_pend <= 1'b0;
`endif
      end else begin
         r_strobe <= 1'b0;
         r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr   <= 1'b0;
`endif
         if (baud_x16) begin
            r_tick <= w_tick_inc;
            if (r_tick == T_LO || r_tick == T_MID)
               r_smp <= {r_smp[0], w_line};
            unique case (r_state)
               IDLE: begin
                  // Out of reset a low line is a break, not a start bit
                  if (!r_armed) begin
                     if (!w_line) begin
                        r_state <= WAIT_IDLE;
                        r_tick  <= '0;
                     end else if (r_tick == T_ARM) begin
                        r_armed <= 1'b1;
                     end
                  end else if (!w_line) begin
                     r_state <= START;
                     r_tick  <= CW'(1);
                  end else begin
                     r_tick <= '0;
                  end
               end
               START: begin
                  if (w_eval) begin
                     r_state <= w_vote ? IDLE : DATA;
                     r_bit   <= '0;
                  end
               end
               DATA: begin
                  if (w_eval) begin
                     r_shift <= {w_vote, r_shift[7:1]};
                     r_bit   <= r_bit + 1'b1;
`ifdef UART_RX_PARITY_EN
                     if (r_bit == B_END) r_state <= PARITY;
`else
                     if (r_bit == B_END) r_state <= STOP;
`endif
                  end
               end
               PARITY: begin
`ifdef UART_RX_PARITY_EN
                  if (w_eval) begin
                     r_perr_pend <= w_vote ^ (^r_shift);
                     r_state     <= STOP;
                  end
`else
                  r_state <= IDLE;
`endif
               end
               STOP: begin
                  if (w_eval) begin
`ifdef UART_RX_PARITY_EN
                     r_perr <= r_perr_pend;
`endif
                     if (w_vote) begin
                        r_data   <= r_shift;
                        r_strobe <= 1'b1;
                        r_state  <= IDLE;
                     end else begin
                        r_ferr  <= 1'b1;
                        r_state <= WAIT_IDLE;
                        r_tick  <= '0;
                     end
                  end
               end
               WAIT_IDLE: begin
                  if (!w_line) begin
                     r_tick <= '0;
                  end else if (r_tick == T_END) begin
                     r_state <= IDLE;
                     r_tick  <= '0;
                     r_armed <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign data          = r_data;
   assign data_strobe   = r_strobe;
   assign framing_error = r_ferr;
   assign busy          = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_error  = r_perr;
`else
   assign parity_error  = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver matching the existing uart_tx: 8N1, LSB first, idle-high line.
- Oversamples the asynchronous serial input using a ×16 baud strobe generated by divide_by_n from the 48 MHz HFOSC clock. At 1 MHz baud this is N=3.
- Delivers each received byte as a one-cycle data_strobe in the mclk domain.
- Sits between the FTDI serial_rxd pin and the echo/command logic in top.

Parameters:
- OVERSAMPLE, 16, baud_x16 ticks per bit; must be even and ≥8.
- SYNC_STAGES, 2, flops in the serial input synchroniser; must be ≥2.

Ports:
- mclk, input, 1, system clock (48 MHz).
- reset_n, input, 1, asynchronous active-low reset.
- baud_x16, input, 1, one-mclk-cycle tick at OVERSAMPLE × baud rate.
- serial, input, 1, asynchronous RX line; idles high.
- data, output, 8, last received byte; held until the next good frame.
- data_strobe, output, 1, one-cycle pulse; data is valid in the same cycle.
- framing_error, output, 1, one-cycle pulse when the stop bit samples low.
- parity_error, output, 1, one-cycle pulse on parity mismatch; tied 0 without the optional feature.
- busy, output, 1, high whenever state ≠ IDLE.

Behaviour:
- Reset: asynchronous assert, synchronous release. All synchroniser flops reset to 1. data=0, data_strobe=0, framing_error=0, parity_error=0, busy=0, state=IDLE, tick counter=0, bit counter=0.
- Sampling: all logic runs on mclk and advances only in cycles where baud_x16=1. Exception: the strobe outputs self-clear on the next mclk cycle.
- Bit value: majority vote of the synchronised line at ticks MID-1, MID and MID+1 of each bit, where MID=OVERSAMPLE/2.
- IDLE:
  - On a tick where the synced line is 0, go to START and clear the tick counter.
  - Line stuck at 0 out of reset: treat as break, go to WAIT_IDLE, no error pulse.
- START: at tick MID+1, evaluate the vote.
  - Vote 1: glitch; return to IDLE, no outputs.
  - Vote 0: go to DATA with bit index 0.
- DATA:
  - Each bit lasts OVERSAMPLE ticks, measured from the start-bit centre alignment.
  - Voted bit shifts into a shift register, LSB first.
  - After bit 7, go to PARITY (feature enabled) or STOP.
- STOP: at the bit centre, evaluate the vote.
  - Vote 1: load data from the shift register, pulse data_strobe next mclk cycle, return to IDLE. IDLE may detect the next start edge after the remaining half bit, so back-to-back frames are supported.
  - Vote 0: pulse framing_error, leave data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: remain until the synced line has been 1 for one full bit (OVERSAMPLE consecutive ticks), then go to IDLE.
- Latency: data_strobe asserts 1–2 mclk cycles after the stop-bit centre tick.
- No backpressure: a consumer that misses data_strobe loses the byte. data is overwritten only on the next good frame.
- reset_n asserted mid-frame: immediate return to the reset state; the partial byte is discarded.
- A baud_x16 tick coincident with strobe self-clear must not lose the tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. PARITY state samples one extra bit and compares it with the XOR of the data bits (even parity).
  - Mismatch: pulse parity_error.
  - A valid stop bit still loads data and pulses data_strobe in the same cycle as parity_error.
- Undefined: no PARITY state, parity_error driven constant 0, frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - State encoding: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - Constants DATA_BITS=8 and UART_MID=OVERSAMPLE/2.
  - Shared by uart_tx.
- Sub-module sync_ff: SYNC_STAGES-deep synchroniser with reset value 1. Reusable for other pad inputs such as buttons.

Test Plan:
- mclk 48 MHz, baud_x16 from divide_by_n N=3; drive 0x41 at 1 MHz 8N1 -> data=0x41 with one data_strobe, framing_error=0, busy low within 1 bit time after the stop bit.
- Back-to-back "\r", "\n", "A" with no idle gap -> three data_strobe pulses carrying 0x0D, 0x0A, 0x41, in order.
- 300 ns low glitch on idle line -> no data_strobe, busy returns to 0, state IDLE.
- Frame 0x55 with the stop bit forced low, then line held low 20 µs -> single framing_error pulse, data unchanged, next valid 0x33 received correctly after the line returns high.
- Baud skew of ±3% (sender at 0.97 and 1.03 MHz), bytes 0x00 and 0xFF -> both received correctly.
- reset_n pulsed low during bit 4 of 0xA5, then a full 0x5A frame -> no strobe for the aborted frame, data=0x5A. With UART_RX_PARITY_EN, a 0x07 frame with parity bit 0 -> parity_error and data_strobe pulse together.
